traffic_timing_sequencer: RTL and testbench

TRAFFIC_TIMING_SEQUENCER -- requirements
Module: traffic_timing_sequencer

---
 rtl/traffic_timing_sequencer.sv | 74 +++++++
 tb/tb_traffic_timing_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_timing_sequencer.sv
// traffic_timing_sequencer: tick-paced signal phase sequencer with pedestrian walk and forced all-red.
module traffic_timing_sequencer #(
    parameter int unsigned DWELL_GREEN  = 4,
    parameter int unsigned DWELL_YELLOW = 3,
    parameter int unsigned DWELL_WALK   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       force_red,
    output logic [3:0] timing_state,
    output logic       ped_wait,
    output logic       ped_ack
);
    localparam logic [3:0] ST_NS_GREEN  = 4'd0;
    localparam logic [3:0] ST_NS_YELLOW = 4'd4;
    localparam logic [3:0] ST_EW_YELLOW = 4'd9;
    localparam logic [3:0] ST_WALK      = 4'd10;
    localparam logic [3:0] ST_ALL_RED   = 4'd15;
    logic [3:0] state_next;
    logic [7:0] count;
    logic [7:0] count_next;
    logic [7:0] dwell;
    logic       advance;
    logic       walk_entry;
    logic       ped_wait_next;
    logic       ped_ack_next;
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (DWELL_GREEN >= 1 && DWELL_GREEN <= 255 &&
                    DWELL_YELLOW >= 1 && DWELL_YELLOW <= 255 &&
                    DWELL_WALK >= 1 && DWELL_WALK <= 255)
            else $error("traffic_timing_sequencer: dwell parameters must be 1..255");
            timing_state <= ST_NS_GREEN;
            count        <= 8'd0;
            ped_wait     <= 1'b0;
            ped_ack      <= 1'b0;
        end else begin
            timing_state <= state_next;
            count        <= count_next;
            ped_wait     <= ped_wait_next;
            ped_ack      <= ped_ack_next;
        end
    end
    always_comb begin
        dwell = (timing_state == ST_WALK) ? 8'(DWELL_WALK) :
                (timing_state == ST_NS_YELLOW || timing_state == ST_EW_YELLOW) ? 8'(DWELL_YELLOW) :
                8'(DWELL_GREEN);
        advance    = tick && (count == dwell - 8'd1);
        state_next = timing_state;
        count_next = count;
        // Override wins over everything; leaving all-red always restarts at NS green.
        if (force_red) begin
            state_next = ST_ALL_RED;
            count_next = 8'd0;
        end else if (timing_state == ST_ALL_RED) begin
            state_next = ST_NS_GREEN;
            count_next = 8'd0;
        end else if (advance) begin
            count_next = 8'd0;
            state_next = (timing_state == ST_EW_YELLOW) ? (ped_wait ? ST_WALK : ST_NS_GREEN) :
                         (timing_state == ST_WALK) ? ST_NS_GREEN :
                         timing_state + 4'd1;
        end else if (tick) begin
            count_next = count + 8'd1;
        end
    end
    always_comb begin
        walk_entry    = (state_next == ST_WALK) && (timing_state != ST_WALK);
        ped_wait_next = !walk_entry && (ped_wait || ped_req);
        ped_ack_next  = walk_entry;
    end
endmodule

// File: tb/tb_traffic_timing_sequencer.sv
// tb_traffic_timing_sequencer: directed vector table, corner sequences and randomized model comparison.
module tb_traffic_timing_sequencer;
    localparam int G = 2;
    localparam int Y = 1;
    localparam int W = 3;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       force_red = 1'b0;
    logic [3:0] timing_state;
    logic       ped_wait;
    logic       ped_ack;
    int n_cmp = 0;
    int n_bad = 0;
    int m_st = 0;
    int m_el = 0;
    bit m_wait = 0;
    bit m_ack = 0;
    typedef struct {
        logic       r, t, q, f;
        logic [3:0] st;
        logic       w, a;
    } vec_t;
    vec_t tbl[$];

    traffic_timing_sequencer #(.DWELL_GREEN(G), .DWELL_YELLOW(Y), .DWELL_WALK(W)) dut (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .force_red(force_red),
        .timing_state(timing_state), .ped_wait(ped_wait), .ped_ack(ped_ack)
    );

    always #5 clk = ~clk;

    function automatic int dwell_of(input int s);
        return (s == 10) ? W : (s == 4 || s == 9) ? Y : G;
    endfunction

    // Reference: phases counted in elapsed ticks, next phase picked from the cycle order.
    task automatic model(input bit r, input bit t, input bit q, input bit f);
        bit enter;
        enter = 0;
        if (r) begin
            m_st = 0; m_el = 0; m_wait = 0; m_ack = 0;
            return;
        end
        if (f) begin
            m_st = 15; m_el = 0;
        end else if (m_st == 15) begin
            m_st = 0; m_el = 0;
        end else if (t) begin
            m_el++;
            if (m_el == dwell_of(m_st)) begin
                m_el = 0;
                if (m_st == 9) m_st = m_wait ? 10 : 0;
                else if (m_st == 10) m_st = 0;
                else m_st++;
                enter = (m_st == 10);
            end
        end
        m_wait = enter ? 1'b0 : (m_wait | q);
        m_ack = enter;
    endtask

    task automatic step(input logic r, input logic t, input logic q, input logic f);
        @(negedge clk);
        rst = r; tick = t; ped_req = q; force_red = f;
        @(posedge clk);
        model(r, t, q, f);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] es, input logic ew, input logic ea);
        n_cmp++;
        if (timing_state !== es || ped_wait !== ew || ped_ack !== ea) begin
            n_bad++;
            $display("FAIL %s: got state=%0d wait=%b ack=%b, need state=%0d wait=%b ack=%b",
                     nm, timing_state, ped_wait, ped_ack, es, ew, ea);
        end
    endtask

    task automatic chk_model(input string nm);
        chk(nm, 4'(m_st), m_wait, m_ack);
    endtask

    task automatic add(input logic r, t, q, f, input logic [3:0] st, input logic w, a);
        tbl.push_back('{r: r, t: t, q: q, f: f, st: st, w: w, a: a});
    endtask

    initial begin
        int seq_a[20] = '{0, 1, 1, 2, 2, 3, 3, 4, 5, 5, 6, 6, 7, 7, 8, 8, 9, 0, 0, 1};
        int seq_b[12] = '{3, 3, 4, 5, 5, 6, 6, 7, 7, 8, 8, 9};
        int seq_c[16] = '{1, 1, 2, 2, 3, 3, 4, 5, 5, 6, 6, 7, 7, 8, 8, 9};
        int prev;
        int prev2;
        int frc_left;
        bit found;
        // Plain cycle, no pedestrian
        add(1, 0, 0, 0, 0, 0, 0);
        foreach (seq_a[i]) add(0, 1, 0, 0, 4'(seq_a[i]), 0, 0);
        // Single request pulse during state 2
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 2, 0, 0);
        add(0, 1, 1, 0, 2, 1, 0);
        foreach (seq_b[i]) add(0, 1, 0, 0, 4'(seq_b[i]), 1, 0);
        add(0, 1, 0, 0, 10, 0, 1);
        add(0, 1, 0, 0, 10, 0, 0);
        add(0, 1, 0, 0, 10, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        // Reset in mid-walk with a pending request
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0);
        foreach (seq_c[i]) add(0, 1, 0, 0, 4'(seq_c[i]), 1, 0);
        add(0, 1, 1, 0, 10, 0, 1);
        add(0, 1, 1, 0, 10, 1, 0);
        add(1, 1, 1, 1, 0, 0, 0);
        // Tick gating holds state and count
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 2, 0, 0);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].t, tbl[i].q, tbl[i].f);
            chk($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].w, tbl[i].a);
        end

        // Force in state 6 for five cycles, request raised during the force
        step(1, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 1, 0, 0);
            chk_model("to_state6");
            found = (timing_state == 4'd6);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL reach_state6: got state=%0d, need state=6 within 40 cycles", timing_state);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1'($urandom_range(1)), (i == 2), 1);
            chk($sformatf("force[%0d]", i), 15, (i >= 2), 0);
        end
        step(0, 0, 0, 0);
        chk("force_exit", 0, 1, 0);
        step(0, 1, 0, 0);
        chk("fresh_dwell0", 0, 1, 0);
        step(0, 1, 0, 0);
        chk("fresh_dwell1", 1, 1, 0);

        // Request held high: every EW yellow leads to walk
        step(1, 0, 0, 0);
        prev = 0;
        prev2 = 0;
        for (int i = 0; i < 80; i++) begin
            step(0, 1, 1, 0);
            chk_model("held_req");
            if (prev == 9) begin
                n_cmp++;
                if (timing_state !== 4'd10) begin
                    n_bad++;
                    $display("FAIL held_9_to_10: got state=%0d, need state=10", timing_state);
                end
            end
            if (prev == 10 && prev2 != 10) begin
                n_cmp++;
                if (ped_wait !== 1'b1) begin
                    n_bad++;
                    $display("FAIL held_rewait: got wait=%b, need wait=1", ped_wait);
                end
            end
            prev2 = prev;
            prev = int'(timing_state);
        end

        // Randomized traffic against the reference model
        step(1, 0, 0, 0);
        chk_model("rand_reset");
        frc_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (frc_left == 0 && $urandom_range(99) < 2) frc_left = $urandom_range(6, 1);
            step(($urandom_range(199) == 0), ($urandom_range(9) < 7), ($urandom_range(19) == 0), (frc_left > 0));
            if (frc_left > 0) frc_left--;
            chk_model($sformatf("rand[%0d]", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
